// File: rtl/s3g_rx_core.sv
// S3G host-protocol receive framer: start-byte hunt, length/payload capture,
// CRC-8 (Maxim, reflected 0x8C) check, and a random-read payload buffer.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | hunting for the start byte
// LEN     | next byte is the payload length
// PAYLOAD | storing payload bytes and folding them into crc
// CRC     | next byte is compared against the running crc
module s3g_rx_core #(
    parameter int         MAX_PAYLOAD = 32,
    parameter logic [7:0] START_BYTE  = 8'hD5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       pkt_valid,
    output logic [5:0] pkt_len,
    output logic       crc_error,
    output logic       len_error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CRC} state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t     state, state_nxt;
    logic [5:0] len_q, len_nxt;
    logic [5:0] idx_q, idx_nxt;
    logic [5:0] pkt_len_q, pkt_len_nxt;
    logic [7:0] crc_q, crc_nxt;
    logic       valid_nxt, crc_err_nxt, len_err_nxt, wr_en;
    logic [7:0] mem [MAX_PAYLOAD];

    // One full byte of the reflected CRC-8, unrolled so a byte fits in one cycle.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            crc_q     <= '0;
            pkt_len_q <= '0;
            pkt_valid <= 1'b0;
            crc_error <= 1'b0;
            len_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            idx_q     <= idx_nxt;
            crc_q     <= crc_nxt;
            pkt_len_q <= pkt_len_nxt;
            pkt_valid <= valid_nxt;
            crc_error <= crc_err_nxt;
            len_error <= len_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        idx_nxt     = idx_q;
        crc_nxt     = crc_q;
        pkt_len_nxt = pkt_len_q;
        valid_nxt   = 1'b0;
        crc_err_nxt = 1'b0;
        len_err_nxt = 1'b0;
        wr_en       = 1'b0;
        if (rx_done) begin
            case (state)
                IDLE: begin
                    if (rx_data == START_BYTE) state_nxt = LEN;
                end
                LEN: begin
                    len_nxt = rx_data[5:0];
                    idx_nxt = '0;
                    crc_nxt = '0;
                    if (rx_data > MAX_LEN) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else if (rx_data == 8'h00) begin
                        state_nxt = CRC;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    wr_en   = 1'b1;
                    crc_nxt = crc8_step(crc_q, rx_data);
                    idx_nxt = idx_q + 6'd1;
                    if (idx_q + 6'd1 == len_q) state_nxt = CRC;
                end
                CRC: begin
                    if (rx_data == crc_q) begin
                        pkt_len_nxt = len_q;
                        valid_nxt   = 1'b1;
                    end else begin
                        crc_err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Buffer is deliberately left out of reset; reads see the pre-edge contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx_q[4:0]] <= rx_data;
    end

    assign rd_data = mem[rd_addr];
    assign pkt_len = pkt_len_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_s3g_rx_core.sv
// Bench for s3g_rx_core: directed frames from the test plan plus random frames,
// with a queue-based scoreboard checked by an independent monitor.
module tb_s3g_rx_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       pkt_valid;
    logic [5:0] pkt_len;
    logic       crc_error;
    logic       len_error;
    logic       busy;

    s3g_rx_core dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pkt_valid (pkt_valid),
        .pkt_len   (pkt_len),
        .crc_error (crc_error),
        .len_error (len_error),
        .busy      (busy)
    );

    always #50 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // kind: 0 good packet, 1 crc error, 2 length error
    int         exp_kind[$];
    int         exp_len[$];
    logic [7:0] exp_data[$];
    int         last_len = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Bit-serial reference: message bits LSB first through the reflected 0x8C divider.
    function automatic logic [7:0] ref_crc(input logic [7:0] d[$]);
        logic [7:0] r = 8'h00;
        logic       fb;
        foreach (d[k]) begin
            for (int j = 0; j < 8; j++) begin
                fb = r[0] ^ d[k][j];
                r  = r >> 1;
                if (fb) r = r ^ 8'h8C;
            end
        end
        return r;
    endfunction

    task automatic push_exp(input int kind, input int len, input logic [7:0] d[$]);
        exp_kind.push_back(kind);
        if (kind == 0) begin
            last_len = len;
            exp_len.push_back(len);
            foreach (d[k]) exp_data.push_back(d[k]);
        end else begin
            exp_len.push_back(last_len);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int gap);
        foreach (s[k]) send_byte(s[k], gap);
    endtask

    task automatic rand_frame();
        int         r, kind, gap, n, len;
        logic [7:0] b, c;
        logic [7:0] pl[$];
        r    = $urandom_range(0, 99);
        kind = (r < 70) ? 0 : (r < 85) ? 1 : 2;
        gap  = $urandom_range(0, 3);
        n    = $urandom_range(0, 2);
        repeat (n) begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hD5);
            send_byte(b, gap);
        end
        if (kind == 2) begin
            b = 8'($urandom_range(33, 255));
            push_exp(2, 0, pl);
            send_byte(8'hD5, gap);
            send_byte(b, gap);
        end else begin
            r   = $urandom_range(0, 9);
            len = (r == 0) ? 0 : (r == 1) ? 32 : $urandom_range(1, 31);
            for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 255)));
            c = ref_crc(pl);
            if (kind == 1) c = c ^ 8'($urandom_range(1, 255));
            push_exp(kind, len, pl);
            send_byte(8'hD5, gap);
            send_byte(8'(len), gap);
            send_seq(pl, gap);
            send_byte(c, gap);
        end
    endtask

    // Monitor: pops one expectation per result pulse and reads back good payloads.
    initial begin
        int   npulse, kind, len;
        logic prev = 1'b0;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            npulse = int'(pkt_valid) + int'(crc_error) + int'(len_error);
            if (npulse > 1) chk("pulse_exclusive", npulse, 1);
            if (npulse > 0 && prev) chk("pulse_one_cycle", 1, 0);
            if (npulse > 0) begin
                kind = pkt_valid ? 0 : crc_error ? 1 : 2;
                if (exp_kind.size() == 0) begin
                    chk("unexpected_pulse_kind", kind, 15);
                end else begin
                    chk("result_kind", kind, exp_kind.pop_front());
                    len = exp_len.pop_front();
                    chk("pkt_len", int'(pkt_len), len);
                    if (kind == 0 && exp_data.size() >= len) begin
                        for (int k = 0; k < len; k++) begin
                            rd_addr = 5'(k);
                            #1;
                            chk("rd_data", int'(rd_data), int'(exp_data.pop_front()));
                        end
                    end
                end
            end
            prev = (npulse > 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] d[$];
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pkt_len", int'(pkt_len), 0);
        chk("reset_pkt_valid", int'(pkt_valid), 0);
        chk("reset_crc_error", int'(crc_error), 0);
        chk("reset_len_error", int'(len_error), 0);
        @(posedge clk);
        #1;

        // good frame with leading noise
        d = '{8'h01, 8'h02, 8'h03};
        push_exp(0, 3, d);
        q = '{8'h0D, 8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
        send_seq(q, 9);

        // bad crc
        push_exp(1, 0, d);
        q = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hCC};
        send_seq(q, 2);

        // zero length, good then bad
        d = {};
        push_exp(0, 0, d);
        q = '{8'hD5, 8'h00, 8'h00};
        send_seq(q, 2);
        push_exp(1, 0, d);
        q = '{8'hD5, 8'h5E};
        send_byte(8'hD5, 2);
        send_byte(8'h00, 2);
        send_byte(8'h5E, 2);

        // length error, busy behaviour, recovery
        push_exp(2, 0, d);
        send_byte(8'hD5, 0);
        chk("busy_after_start", int'(busy), 1);
        send_byte(8'h21, 0);
        chk("busy_after_len_error", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        d = '{8'h01};
        push_exp(0, 1, d);
        q = '{8'hD5, 8'h01, 8'h01, 8'h5E};
        send_seq(q, 1);

        // back-to-back strobes, 0xD5 inside the frame is data
        d = '{8'hD5, 8'h01};
        push_exp(0, 2, d);
        q = '{8'hD5, 8'h02, 8'hD5, 8'h01};
        send_seq(q, 0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(ref_crc(d), 3);

        // reset mid-frame
        q = '{8'hD5, 8'h03, 8'h01};
        send_seq(q, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_len = 0;
        chk("midframe_reset_busy", int'(busy), 0);
        chk("midframe_reset_pkt_len", int'(pkt_len), 0);
        d = '{8'h01};
        push_exp(0, 1, d);
        q = '{8'hD5, 8'h01, 8'h01, 8'h5E};
        send_seq(q, 1);

        repeat (40) rand_frame();

        for (int k = 0; k < 50 && exp_kind.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_kind.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
